comp_logic_n_pipe: RTL and testbench

// - Parametrised, op-selectable N-input bitwise gate with a single registered stage and valid/ready handshake.
// - Generalises the 2-input AND component to WIDTH-bit operands, NUM_IN operands and six ops.
// - Sits between the ASCII operand-decode path and the adder datapath, wherever masking, combining or parity is needed.
// - Counts completed transactions.

---
 rtl/comp_logic_n_pipe.sv | 123 ++++++++++++
 tb/tb_comp_logic_n_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_logic_n_pipe.sv
// comp_logic_n_pipe: NUM_IN-operand bitwise gate (AND/OR/XOR and inverses),
// one registered stage, valid/ready on both sides, consumed-result counter.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready/in_data/in_op     operand beat, op 0..5 legal
//   out_valid/out_ready/out_data/out_err result beat, err on op 6/7
//   op_count                             results consumed since reset
// Macro LOGIC_REDUCE_EN adds registered out_all/out_any/out_par.
module comp_logic_n_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [CNT_W-1:0]        op_count
`ifdef LOGIC_REDUCE_EN
  ,
  output logic                    out_all,
  output logic                    out_any,
  output logic                    out_par
`endif
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_acc;
  logic             w_take;

  // Nothing is accepted while reset is asserted.
  assign in_ready = !rst && (!r_valid || out_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_take   = r_valid && out_ready;

  always_comb begin
    w_and = '1;
    w_or  = '0;
    w_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_and = w_and & in_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | in_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  // Inverting ops negate the whole fold, not each pair.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    unique case (in_op)
      3'd0:    w_res = w_and;
      3'd1:    w_res = w_or;
      3'd2:    w_res = w_xor;
      3'd3:    w_res = ~w_and;
      3'd4:    w_res = ~w_or;
      3'd5:    w_res = ~w_xor;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_take)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_acc) begin
        r_valid <= 1'b1;
        r_data  <= w_res;
        r_err   <= w_err;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_err   = r_err;
  assign op_count  = r_cnt;

`ifdef LOGIC_REDUCE_EN
  logic r_all;
  logic r_any;
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_all <= 1'b0;
      r_any <= 1'b0;
      r_par <= 1'b0;
    end else if (w_acc) begin
      r_all <= &w_res;
      r_any <= |w_res;
      r_par <= ^w_res;
    end
  end

  assign out_all = r_all;
  assign out_any = r_any;
  assign out_par = r_par;
`endif

endmodule

// File: tb/tb_comp_logic_n_pipe.sv
// tb_comp_logic_n_pipe: directed vectors for comp_logic_n_pipe,
// three instances (default, NUM_IN=3, CNT_W=4).
module tb_comp_logic_n_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: WIDTH=8 NUM_IN=2 CNT_W=16
  logic        a_iv, a_ir, a_ov, a_or, a_err;
  logic [15:0] a_id;
  logic [2:0]  a_op;
  logic [7:0]  a_od;
  logic [15:0] a_cnt;

  // instance B: NUM_IN=3
  logic        b_iv, b_ir, b_ov, b_or, b_err;
  logic [23:0] b_id;
  logic [2:0]  b_op;
  logic [7:0]  b_od;
  logic [15:0] b_cnt;

  // instance C: CNT_W=4
  logic        c_iv, c_ir, c_ov, c_or, c_err;
  logic [15:0] c_id;
  logic [2:0]  c_op;
  logic [7:0]  c_od;
  logic [3:0]  c_cnt;

`ifdef LOGIC_REDUCE_EN
  logic a_all, a_any, a_par;
  logic b_all, b_any, b_par;
  logic c_all, c_any, c_par;
`endif

  comp_logic_n_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_op(a_op),
    .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .out_err(a_err),
    .op_count(a_cnt)
`ifdef LOGIC_REDUCE_EN
    , .out_all(a_all), .out_any(a_any), .out_par(a_par)
`endif
  );

  comp_logic_n_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_op(b_op),
    .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .out_err(b_err),
    .op_count(b_cnt)
`ifdef LOGIC_REDUCE_EN
    , .out_all(b_all), .out_any(b_any), .out_par(b_par)
`endif
  );

  comp_logic_n_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_id), .in_op(c_op),
    .out_valid(c_ov), .out_ready(c_or),
    .out_data(c_od), .out_err(c_err),
    .op_count(c_cnt)
`ifdef LOGIC_REDUCE_EN
    , .out_all(c_all), .out_any(c_any), .out_par(c_par)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: results consumed from instance A.
  logic [7:0] sb_got[$];
  always @(posedge clk)
    if (!rst && a_ov && a_or)
      sb_got.push_back(a_od);

  logic [7:0] exp_t2 [6];

  initial begin
    exp_t2[0] = 8'h0C; exp_t2[1] = 8'h3F; exp_t2[2] = 8'h33;
    exp_t2[3] = 8'hF3; exp_t2[4] = 8'hC0; exp_t2[5] = 8'hCC;

    rst  = 1'b1;
    a_iv = 1'b1; a_id = 16'h0F3C; a_op = 3'd0; a_or = 1'b1;
    b_iv = 1'b0; b_id = '0;       b_op = 3'd0; b_or = 1'b1;
    c_iv = 1'b0; c_id = '0;       c_op = 3'd0; c_or = 1'b1;

    // T1 reset with in_valid held
    #1;
    check("t1_in_ready", a_ir, 0);
    step();
    step();
    check("t1_out_valid", a_ov, 0);
    check("t1_out_data", a_od, 8'h00);
    check("t1_op_count", a_cnt, 0);
    check("t1_in_ready2", a_ir, 0);
    rst  = 1'b0;
    a_iv = 1'b0;
    step();
    check("t1_no_accept", a_ov, 0);

    // T2 all six ops back to back
    a_id = {8'h0F, 8'h3C};
    a_or = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_iv = 1'b1;
      a_op = 3'(i);
      step();
      check($sformatf("t2_valid_op%0d", i), a_ov, 1);
      check($sformatf("t2_data_op%0d", i), a_od, exp_t2[i]);
    end
    check("t2_cnt5", a_cnt, 5);
    a_iv = 1'b0;
    step();
    check("t2_cnt6", a_cnt, 6);
    check("t2_drained", a_ov, 0);

    // T3 stall for 3 cycles
    sb_got.delete();
    a_iv = 1'b1; a_id = {8'h0F, 8'hAA}; a_op = 3'd1; a_or = 1'b1;
    step();
    check("t3_first", a_od, 8'hAF);
    a_or = 1'b0; a_id = {8'hF0, 8'h55}; a_op = 3'd0;
    #1;
    check("t3_ready_lo", a_ir, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t3_hold_data%0d", i), a_od, 8'hAF);
      check($sformatf("t3_hold_vld%0d", i), a_ov, 1);
      check($sformatf("t3_hold_rdy%0d", i), a_ir, 0);
    end
    a_or = 1'b1;
    #1;
    check("t3_ready_hi", a_ir, 1);
    step();
    check("t3_second", a_od, 8'h50);
    a_iv = 1'b0;
    step();
    check("t3_sb_size", sb_got.size(), 2);
    check("t3_sb_data",
          (sb_got.size() == 2) ? {16'h0, sb_got[0], sb_got[1]} : 32'h0,
          32'h0000_AF50);
    check("t3_cnt", a_cnt, 8);

    // T4 illegal ops
    a_iv = 1'b1; a_id = 16'hFFFF; a_op = 3'd7;
    step();
    check("t4_op7_data", a_od, 8'h00);
    check("t4_op7_err", a_err, 1);
    a_op = 3'd6; a_id = 16'h1234;
    step();
    check("t4_op6_data", a_od, 8'h00);
    check("t4_op6_err", a_err, 1);
    check("t4_cnt_a", a_cnt, 9);
    a_op = 3'd0; a_id = 16'hFFFF;
    step();
    check("t4_legal_data", a_od, 8'hFF);
    check("t4_legal_err", a_err, 0);
    a_iv = 1'b0;
    step();
    check("t4_cnt_b", a_cnt, 11);

    // T5 three operands
    b_iv = 1'b1; b_id = {8'h04, 8'h02, 8'h01}; b_op = 3'd5;
    step();
    check("t5_xnor3", b_od, 8'hF8);
    check("t5_err", b_err, 0);
`ifdef LOGIC_REDUCE_EN
    check("t5_all", b_all, 0);
    check("t5_any", b_any, 1);
    check("t5_par", b_par, 1);
`endif
    b_id = {8'h3C, 8'h0F, 8'hFF}; b_op = 3'd0;
    step();
    check("t5_and3", b_od, 8'h0C);
    b_id = {8'h80, 8'h01, 8'h10}; b_op = 3'd4;
    step();
    check("t5_nor3", b_od, 8'h6E);
    b_iv = 1'b0;
    step();
    check("t5_cnt", b_cnt, 3);

    // T6 counter wrap, then reset mid-transaction
    c_iv = 1'b1; c_id = 16'h00F0; c_op = 3'd1; c_or = 1'b1;
    for (int i = 0; i < 17; i++)
      step();
    c_iv = 1'b0;
    step();
    check("t6_wrap", c_cnt, 1);
    check("t6_idle", c_ov, 0);
    c_iv = 1'b1; c_or = 1'b0;
    step();
    check("t6_pending", c_ov, 1);
    check("t6_pend_data", c_od, 8'hF0);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", c_ir, 0);
    step();
    check("t6_rst_valid", c_ov, 0);
    check("t6_rst_cnt", c_cnt, 0);
    check("t6_rst_data", c_od, 8'h00);
    check("t6_rst_cnt_a", a_cnt, 0);
    rst  = 1'b0;
    c_iv = 1'b0;
    step();
    check("t6_after", c_ov, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
